qam16_symbol_source: RTL and testbench
======================================

// Module: qam16_symbol_source
// PURPOSE
// Transmit-side symbol source on one clock. A 4-bit phase counter generates a sample
// strobe (1-in-4) and a symbol strobe (1-in-16). A maximal-length Fibonacci LFSR advances
// once per symbol and supplies 4-bit symbols. A 16-QAM Gray mapper turns each symbol into
// registered 18-bit signed I/Q levels that feed the upsampler/pulse-shaping filter.
// PARAMETERS
// LFSR_LEN  22        LFSR width; must be >= 4.
// TAPS      22'h200001  feedback mask; bit k set => state[k] is XORed into feedback.
// SEED      1         reset/start state; nonzero.
// PORTS
// clk                   in   1        system clock; all logic rises on posedge.
// reset                 in   1        asynchronous, active-low reset.
// sample_en             out  1        one-clk strobe, high when phase[1:0]==3.
// sym_en                out  1        one-clk strobe, high when phase==15.
// phase                 out  4        free-running count 0..15.
// seq_out               out  LFSR_LEN current LFSR state.
// sym_out               out  4        seq_out[3:0].
// cycle_out             out  1        level; high while seq_out==SEED.
// cycle_out_periodic    out  1        level; high while lfsr_counter==0.
// cycle_out_periodic_ahead  out 1     level; high while lfsr_counter==2^LFSR_LEN-2.
// cycle_out_periodic_behind out 1     level; high while lfsr_counter==1.
// lfsr_counter          out  LFSR_LEN symbol index 0..2^LFSR_LEN-2, then wraps.
// in_phs_sig            out  18 s     I level, signed 1s17.
// quad_sig              out  18 s     Q level, signed 1s17.
// BEHAVIOUR
// - Reset asserted (reset==0), asynchronously:
//   - phase=0, seq_out=SEED, lfsr_counter=0;
//   - in_phs_sig=quad_sig=0.
//   - Strobes are decoded from phase, so they are 0 in reset.
// - phase increments by 1 every clk and wraps 15->0.
// - sample_en and sym_en are combinational decodes of registered phase.
// - First sym_en is on the 16th rising edge after reset deasserts.
// - On an edge with sym_en=1:
//   - state <= {state[LFSR_LEN-2:0], ^(state & TAPS)};
//   - lfsr_counter <= (lfsr_counter==2^LFSR_LEN-2) ? 0 : lfsr_counter+1;
//   - in_phs_sig/quad_sig <= map(sym_out) using the pre-advance sym_out.
//   - Mapped I/Q therefore lags the LFSR symbol by exactly one symbol period.
//   - All three updates occur on the same edge.
// - Outputs hold between sym_en edges; no other input affects them.
// - 16-QAM Gray map, 2 bits -> level:
//   - 00 -> -98304 (-0.75); 01 -> -32768 (-0.25); 11 -> +32768; 10 -> +98304.
//   - I uses sym_out[3:2]; Q uses sym_out[1:0].
// - With TAPS primitive, state and counter return to SEED and 0 together.
//   - cycle_out == cycle_out_periodic on every cycle; the bench checks the taps this way.
// - Reset mid-operation: immediate return to reset values.
//   - Sequence restarts from SEED; the first post-reset sym_en is again 16 clks later.
// - An all-zero state is unreachable with nonzero SEED; no lock-up recovery is required.
// STRUCTURE
// - Shared package: LFSR_LEN/TAPS/SEED defaults; QAM level constants
//   (LVL_3N, LVL_1N, LVL_1P, LVL_3P); 18-bit sample width define.
// - One sub-module: lfsr_max_gen.
//   - Contents: state register, counter, cycle_out* decodes.
//   - Enabled by sym_en.
// - Phase counter and mapper sit in the top level.
// TESTING
// - Use LFSR_LEN=4, TAPS=4'b1001, SEED=1 unless stated.
// - Reset release: phase 0..15; sample_en at phases 3,7,11,15.
//   - sym_en only at phase 15, 16th edge; in_phs_sig/quad_sig read 0 before that edge.
// - Sequence check:
//   - seq_out = 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8, then 1.
//   - Period 15 symbols; cycle_out and cycle_out_periodic high together only at state 1.
// - Mapping:
//   - After 1st sym_en, I=-98304, Q=-32768 (sym 0001).
//   - After 2nd sym_en, I=-98304, Q=+32768 (sym 0011).
//   - After 4th sym_en, I=+32768, Q=+32768 (sym 1111).
// - Counter flags:
//   - ahead is high exactly at counter 14; periodic at 0; behind at 1.
//   - The counter wraps 14->0.
// - Mid-run reset: assert reset at phase 9 of symbol 5.
//   - All outputs go to reset values asynchronously, with no clk edge needed.
//   - After release, the sequence restarts at 1.
// - Default 22-bit config: first three states are 000001, 000003, 000007 (hex).
//   - lfsr_counter reads 3 after 3 symbols.

Source files
------------

// File: rtl/qam16_symbol_source_pkg.sv
// Shared parameters and 16-QAM level constants for the symbol source.
package qam16_symbol_source_pkg;

  localparam int          LFSR_LEN_DEF = 22;
  localparam logic [21:0] TAPS_DEF     = 22'h200001;
  localparam logic [21:0] SEED_DEF     = 22'h000001;

  localparam int SAMPLE_W = 18;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Levels in signed 1s17: +/-0.75 and +/-0.25 of full scale.
  localparam sample_t LVL_3N = -18'sd98304;
  localparam sample_t LVL_1N = -18'sd32768;
  localparam sample_t LVL_1P =  18'sd32768;
  localparam sample_t LVL_3P =  18'sd98304;

  // Gray-coded pair to level: adjacent levels differ in one bit.
  function automatic sample_t gray_level(input logic [1:0] bits);
    sample_t lvl;
    case (bits)
      2'b00:   lvl = LVL_3N;
      2'b01:   lvl = LVL_1N;
      2'b11:   lvl = LVL_1P;
      default: lvl = LVL_3P;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_symbol_source_lfsr_max_gen.sv
// Fibonacci LFSR with a companion symbol counter; both advance only when en is high.
module lfsr_max_gen
  import qam16_symbol_source_pkg::*;
#(
  parameter int                  LFSR_LEN = LFSR_LEN_DEF,
  parameter logic [LFSR_LEN-1:0] TAPS     = TAPS_DEF,
  parameter logic [LFSR_LEN-1:0] SEED     = SEED_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [LFSR_LEN-1:0] seq_out,
  output logic [LFSR_LEN-1:0] lfsr_counter,
  output logic                cycle_out,
  output logic                cycle_out_periodic,
  output logic                cycle_out_periodic_ahead,
  output logic                cycle_out_periodic_behind
);

  // The counter spans one full maximal period: 0 .. 2^LFSR_LEN-2.
  localparam logic [LFSR_LEN-1:0] CNT_LAST = {{(LFSR_LEN-1){1'b1}}, 1'b0};
  localparam logic [LFSR_LEN-1:0] CNT_ONE  = {{(LFSR_LEN-1){1'b0}}, 1'b1};
  localparam logic [LFSR_LEN-1:0] CNT_ZERO = '0;

  logic feedback;

  assign feedback = ^(seq_out & TAPS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_out      <= SEED;
      lfsr_counter <= CNT_ZERO;
    end else if (en) begin
      seq_out      <= {seq_out[LFSR_LEN-2:0], feedback};
      lfsr_counter <= (lfsr_counter == CNT_LAST) ? CNT_ZERO : lfsr_counter + CNT_ONE;
    end
  end

  assign cycle_out                 = (seq_out == SEED);
  assign cycle_out_periodic        = (lfsr_counter == CNT_ZERO);
  assign cycle_out_periodic_ahead  = (lfsr_counter == CNT_LAST);
  assign cycle_out_periodic_behind = (lfsr_counter == CNT_ONE);

endmodule

// File: rtl/qam16_symbol_source.sv
// 16-QAM transmit symbol source: phase strobes, LFSR symbol generator and Gray I/Q mapper.
module qam16_symbol_source
  import qam16_symbol_source_pkg::*;
#(
  parameter int                  LFSR_LEN = LFSR_LEN_DEF,
  parameter logic [LFSR_LEN-1:0] TAPS     = TAPS_DEF,
  parameter logic [LFSR_LEN-1:0] SEED     = SEED_DEF
) (
  input  logic                clk,
  input  logic                reset,
  output logic                sample_en,
  output logic                sym_en,
  output logic [3:0]          phase,
  output logic [LFSR_LEN-1:0] seq_out,
  output logic [3:0]          sym_out,
  output logic                cycle_out,
  output logic                cycle_out_periodic,
  output logic                cycle_out_periodic_ahead,
  output logic                cycle_out_periodic_behind,
  output logic [LFSR_LEN-1:0] lfsr_counter,
  output sample_t             in_phs_sig,
  output sample_t             quad_sig
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase <= 4'd0;
    else        phase <= phase + 4'd1;
  end

  assign sample_en = &phase[1:0];
  assign sym_en    = &phase;

  lfsr_max_gen #(
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (TAPS),
    .SEED     (SEED)
  ) u_lfsr (
    .clk                       (clk),
    .reset                     (reset),
    .en                        (sym_en),
    .seq_out                   (seq_out),
    .lfsr_counter              (lfsr_counter),
    .cycle_out                 (cycle_out),
    .cycle_out_periodic        (cycle_out_periodic),
    .cycle_out_periodic_ahead  (cycle_out_periodic_ahead),
    .cycle_out_periodic_behind (cycle_out_periodic_behind)
  );

  assign sym_out = seq_out[3:0];

  // Mapped from the pre-advance symbol, so I/Q trail the LFSR by one symbol period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_phs_sig <= '0;
      quad_sig   <= '0;
    end else if (sym_en) begin
      in_phs_sig <= gray_level(sym_out[3:2]);
      quad_sig   <= gray_level(sym_out[1:0]);
    end
  end

endmodule

// File: tb/tb_qam16_symbol_source.sv
// Self-checking bench: a 4-bit and a default 22-bit instance against a cycle-level reference model.
module tb_qam16_symbol_source;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic        sample_en4, sym_en4, co4, cop4, coa4, cob4;
  logic [3:0]  phase4, seq4, cnt4, sym4;
  logic signed [17:0] i4, q4;

  logic        sample_en22, sym_en22, co22, cop22, coa22, cob22;
  logic [3:0]  phase22, sym22;
  logic [21:0] seq22, cnt22;
  logic signed [17:0] i22, q22;

  qam16_symbol_source #(.LFSR_LEN(4), .TAPS(4'b1001), .SEED(4'd1)) dut4 (
    .clk(clk), .reset(reset), .sample_en(sample_en4), .sym_en(sym_en4), .phase(phase4),
    .seq_out(seq4), .sym_out(sym4), .cycle_out(co4), .cycle_out_periodic(cop4),
    .cycle_out_periodic_ahead(coa4), .cycle_out_periodic_behind(cob4),
    .lfsr_counter(cnt4), .in_phs_sig(i4), .quad_sig(q4)
  );

  qam16_symbol_source dut22 (
    .clk(clk), .reset(reset), .sample_en(sample_en22), .sym_en(sym_en22), .phase(phase22),
    .seq_out(seq22), .sym_out(sym22), .cycle_out(co22), .cycle_out_periodic(cop22),
    .cycle_out_periodic_ahead(coa22), .cycle_out_periodic_behind(cob22),
    .lfsr_counter(cnt22), .in_phs_sig(i22), .quad_sig(q22)
  );

  // Reference model: index 0 is the 4-bit config, index 1 the default 22-bit config.
  int    m_len [2] = '{4, 22};
  longint m_taps [2] = '{64'h9, 64'h200001};
  longint m_state [2];
  longint m_cnt [2];
  longint m_i [2];
  longint m_q [2];
  int    m_phase;
  int    m_syms;

  longint seq_tbl [15] = '{1, 3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8};
  longint seq22_tbl [4] = '{1, 3, 7, 15};

  function automatic longint level(input longint bits);
    case (bits)
      0:       return -98304;
      1:       return -32768;
      3:       return 32768;
      default: return 98304;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0;
      m_syms  = 0;
      for (int d = 0; d < 2; d++) begin
        m_state[d] = 1; m_cnt[d] = 0; m_i[d] = 0; m_q[d] = 0;
      end
    end else begin
      if (m_phase == 15) begin
        m_syms++;
        for (int d = 0; d < 2; d++) begin
          longint mask, nxt;
          mask = (64'd1 << m_len[d]) - 1;
          m_i[d] = level((m_state[d] >> 2) % 4);
          m_q[d] = level(m_state[d] % 4);
          nxt = ((m_state[d] << 1) | ($countones(m_state[d] & m_taps[d]) % 2)) & mask;
          m_state[d] = nxt;
          m_cnt[d] = (m_cnt[d] == mask - 1) ? 0 : m_cnt[d] + 1;
        end
      end
      m_phase = (m_phase + 1) % 16;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_lfsr(input string tag, input int d, input longint seq, input longint cnt,
                            input longint co, input longint cop, input longint coa,
                            input longint cob, input longint ii, input longint qq,
                            input longint sym);
    longint last;
    last = (64'd1 << m_len[d]) - 2;
    check({tag, "_seq"},    seq, m_state[d]);
    check({tag, "_sym"},    sym, m_state[d] % 16);
    check({tag, "_cnt"},    cnt, m_cnt[d]);
    check({tag, "_cycle"},  co,  longint'(m_state[d] == 1));
    check({tag, "_per"},    cop, longint'(m_cnt[d] == 0));
    check({tag, "_ahead"},  coa, longint'(m_cnt[d] == last));
    check({tag, "_behind"}, cob, longint'(m_cnt[d] == 1));
    check({tag, "_i"},      ii,  m_i[d]);
    check({tag, "_q"},      qq,  m_q[d]);
  endtask

  task automatic compare_all();
    check("phase4",     phase4,      m_phase);
    check("phase22",    phase22,     m_phase);
    check("sample_en4", sample_en4,  longint'(m_phase % 4 == 3));
    check("sample_en22", sample_en22, longint'(m_phase % 4 == 3));
    check("sym_en4",    sym_en4,     longint'(m_phase == 15));
    check("sym_en22",   sym_en22,    longint'(m_phase == 15));
    check_lfsr("l4", 0, seq4, cnt4, co4, cop4, coa4, cob4, i4, q4, sym4);
    check_lfsr("l22", 1, seq22, cnt22, co22, cop22, coa22, cob22, i22, q22, sym22);
    check("seq_tbl", seq4, seq_tbl[m_syms % 15]);
    if (m_syms < 4) check("seq22_tbl", seq22, seq22_tbl[m_syms]);
    if (m_syms == 3) check("cnt22_at3", cnt22, 3);
    if (m_syms == 1) begin check("map1_i", i4, -98304); check("map1_q", q4, -32768); end
    if (m_syms == 2) begin check("map2_i", i4, -98304); check("map2_q", q4, 32768); end
    if (m_syms == 4) begin check("map4_i", i4, 32768);  check("map4_q", q4, 32768); end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  // Called just after a negedge: asserts reset between edges and checks the asynchronous effect.
  task automatic do_reset(input int hold);
    #2 reset = 1'b0;
    #1;
    check("rst_phase", phase4, 0);
    check("rst_seq",   seq4, 1);
    check("rst_cnt",   cnt4, 0);
    check("rst_i",     i4, 0);
    check("rst_q",     q4, 0);
    check("rst_sym_en", sym_en4, 0);
    compare_all();
    run_cycles(hold);
    #2 reset = 1'b1;
  endtask

  initial begin
    int budget;
    #22;
    compare_all();
    check("rst_seq22", seq22, 1);
    @(negedge clk);
    #2 reset = 1'b1;

    // Run up to phase 9 of symbol 5, then reset mid-symbol.
    budget = 0;
    do begin
      @(negedge clk);
      compare_all();
      budget++;
    end while (!(m_syms == 5 && m_phase == 9) && budget < 300);
    check("reach_sym5_ph9", longint'(m_syms == 5 && m_phase == 9), 1);
    do_reset(2);

    // Cover counter wrap and several full LFSR periods.
    run_cycles(16 * 35);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compare_all();
      do_reset($urandom_range(0, 4));
      run_cycles($urandom_range(10, 400));
    end

    run_cycles(16 * 16);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
